// File: rtl/sbox_byte_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------------+
// | sbox_byte_scheduler: serialises a word through one shared pipelined S-box    |
// | and reassembles the substituted bytes in order.                              |
// | Revision: 1.0                                                                |
// +------------------------------------------------------------------------------+
module sbox_byte_scheduler #(
  parameter int NBYTES   = 16,
  parameter int SBOX_LAT = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_inv,
  input  logic [8*NBYTES-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_data,
  output logic                sbox_vld,
  output logic [7:0]          sbox_in,
  output logic                sbox_inv,
  input  logic [7:0]          sbox_out
);

  localparam int            CW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int            DW   = 8 * NBYTES;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] job_q, job_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [CW-1:0] icnt_q, icnt_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [CW-1:0] icnt_nxt;
  logic          sbox_vld_q, sbox_vld_d;
  logic          sbox_inv_q, sbox_inv_d;
  logic [7:0]    sbox_in_q, sbox_in_d;
  logic          ret_vld;
  logic          last_ret;

  // ret_vld marks the cycle in which sbox_out carries the result of an issued byte.
  generate
    if (SBOX_LAT == 0) begin : g_comb
      assign ret_vld = sbox_vld_q;
    end else begin : g_dly
      logic [SBOX_LAT-1:0] dly_q, dly_d;

      always_comb begin
        dly_d = '0;
        if (!flush) begin
          dly_d[0] = sbox_vld_q;
          for (int i = 1; i < SBOX_LAT; i++) begin
            dly_d[i] = dly_q[i-1];
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          dly_q <= '0;
        end else begin
          dly_q <= dly_d;
        end
      end

      assign ret_vld = dly_q[SBOX_LAT-1];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    job_d      = job_q;
    out_data_d = out_data_q;
    icnt_d     = icnt_q;
    rcnt_d     = rcnt_q;
    sbox_vld_d = 1'b0;
    sbox_in_d  = sbox_in_q;
    sbox_inv_d = sbox_inv_q;
    icnt_nxt   = icnt_q + CW'(1);
    last_ret   = ret_vld && (rcnt_q == LAST);

    if (flush) begin
      // In-flight results are dropped: the delay line is cleared alongside.
      state_d = S_IDLE;
      icnt_d  = '0;
      rcnt_d  = '0;
    end else begin
      if (ret_vld) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (rcnt_q == CW'(b)) begin
            out_data_d[b*8 +: 8] = sbox_out;
          end
        end
        rcnt_d = (rcnt_q == LAST) ? '0 : rcnt_q + CW'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            job_d      = in_data;
            sbox_inv_d = in_inv;
            sbox_in_d  = in_data[7:0];
            sbox_vld_d = 1'b1;
            icnt_d     = '0;
            state_d    = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (icnt_q == LAST) begin
            icnt_d  = '0;
            state_d = (SBOX_LAT == 0) ? S_DONE : S_DRAIN;
          end else begin
            icnt_d     = icnt_nxt;
            sbox_vld_d = 1'b1;
            for (int b = 0; b < NBYTES; b++) begin
              if (icnt_nxt == CW'(b)) begin
                sbox_in_d = job_q[b*8 +: 8];
              end
            end
          end
        end
        S_DRAIN: begin
          if (last_ret) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      job_q      <= '0;
      out_data_q <= '0;
      icnt_q     <= '0;
      rcnt_q     <= '0;
      sbox_vld_q <= 1'b0;
      sbox_in_q  <= 8'h00;
      sbox_inv_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      job_q      <= job_d;
      out_data_q <= out_data_d;
      icnt_q     <= icnt_d;
      rcnt_q     <= rcnt_d;
      sbox_vld_q <= sbox_vld_d;
      sbox_in_q  <= sbox_in_d;
      sbox_inv_q <= sbox_inv_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_data_q;
  assign sbox_vld  = sbox_vld_q;
  assign sbox_in   = sbox_in_q;
  assign sbox_inv  = sbox_inv_q;

endmodule
`default_nettype wire
